ym_tdm_cnt: RTL and testbench

YM_TDM_CNT -- requirements
Module: ym_tdm_cnt

---
 rtl/ym_pkg.sv | 35 +++
 rtl/ym_sr_word.sv | 32 +++
 rtl/ym_tdm_cnt.sv | 101 ++++++++++
 tb/tb_ym_tdm_cnt.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed counter.
package ym_pkg;

  localparam int unsigned MaxDataWidth = 16;
  localparam int unsigned MaxChannels  = 32;

  typedef enum logic [1:0] {
    OpCount,
    OpSet,
    OpLoad,
    OpClr
  } op_e;

  // Index width for n slots, never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic bit params_ok(input int unsigned dw, input int unsigned ch,
                                   input int unsigned sat);
    return (dw >= 1) && (dw <= MaxDataWidth) && (ch >= 1) && (ch <= MaxChannels) &&
           (sat <= 1);
  endfunction

  function automatic op_e sel_op(input logic clr, input logic load, input logic set);
    if (clr)       return OpClr;
    else if (load) return OpLoad;
    else if (set)  return OpSet;
    else           return OpCount;
  endfunction

endpackage

// File: rtl/ym_sr_word.sv
// Two-phase circulating word store: cap fills the stage buffer, shift moves it into the tail.
module ym_sr_word #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CHANNELS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stage_q;
  logic [DATA_WIDTH-1:0] mem_q [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) mem_q[i] <= '0;
    end else begin
      if (cap) stage_q <= d;
      if (shift) begin
        for (int i = 0; i < int'(CHANNELS) - 1; i++) mem_q[i] <= mem_q[i+1];
        mem_q[CHANNELS-1] <= stage_q;
      end
    end
  end

  assign q = mem_q[0];

endmodule

// File: rtl/ym_tdm_cnt.sv
// Time-multiplexed up/down counter: one arithmetic unit shared by CHANNELS slots in a
// circulating store; slot index and sync handling live here.
module ym_tdm_cnt
  import ym_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CHANNELS   = 6,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                        MCLK,
  input  logic                        MRESET_n,
  input  logic                        c1,
  input  logic                        c2,
  input  logic                        sync,
  input  logic                        c_in,
  input  logic                        dec,
  input  logic                        clr,
  input  logic                        set,
  input  logic                        load,
  input  logic [DATA_WIDTH-1:0]       load_val,
  output logic [DATA_WIDTH-1:0]       val,
  output logic [clog2(CHANNELS)-1:0]  slot,
  output logic                        c_out,
  output logic                        slot0
);

  localparam int unsigned SlotW = clog2(CHANNELS);
  localparam int unsigned SumW  = DATA_WIDTH + 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(CHANNELS - 1);

  if (!params_ok(DATA_WIDTH, CHANNELS, SATURATE)) begin : g_param_err
    $error("ym_tdm_cnt: parameter out of range");
  end

  logic [SlotW-1:0]      slot_q, slot_d;
  logic                  sync_q, sync_d;
  logic [DATA_WIDTH-1:0] next_val;
  logic [DATA_WIDTH-1:0] cnt_val;
  logic [SumW-1:0]       sum;
  logic                  carry;
  logic                  c_out_raw;
  op_e                   op;

  always_comb begin
    slot_d = slot_q;
    sync_d = sync_q;
    if (c1) begin
      sync_d = sync;
    end else if (c2) begin
      sync_d = 1'b0;
      if (sync_q || slot_q == LastSlot) slot_d = '0;
      else                              slot_d = slot_q + SlotW'(1);
    end
  end

  always_ff @(posedge MCLK or negedge MRESET_n) begin
    if (!MRESET_n) begin
      slot_q <= '0;
      sync_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      sync_q <= sync_d;
    end
  end

  // Extra top bit of the sum is the carry on increment and the borrow on decrement.
  always_comb begin
    op    = sel_op(clr, load, set);
    sum   = dec ? ({1'b0, val} - SumW'(c_in)) : ({1'b0, val} + SumW'(c_in));
    carry = sum[DATA_WIDTH];
    cnt_val = sum[DATA_WIDTH-1:0];
    if (SATURATE != 0 && carry) cnt_val = val;
    c_out_raw = 1'b0;
    unique case (op)
      OpClr:   next_val = '0;
      OpLoad:  next_val = load_val;
      OpSet:   next_val = '1;
      default: begin
        next_val  = cnt_val;
        c_out_raw = carry;
      end
    endcase
  end

  ym_sr_word #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS)
  ) u_store (
    .clk   (MCLK),
    .rst_n (MRESET_n),
    .cap   (c1),
    .shift (c2),
    .d     (next_val),
    .q     (val)
  );

  assign slot  = slot_q;
  assign slot0 = (slot_q == '0);
  assign c_out = MRESET_n & c_out_raw;

endmodule

// File: tb/tb_ym_tdm_cnt.sv
// Bench for ym_tdm_cnt: wrapping and saturating instances driven in lockstep against a slot model.
module tb_ym_tdm_cnt;

  localparam int DW = 4;
  localparam int CH = 6;
  localparam int SW = 3;

  logic MCLK = 1'b0;
  logic MRESET_n, c1, c2, sync, c_in, dec, clr, set, load;
  logic [DW-1:0] load_val;
  logic [DW-1:0] val_w, val_s;
  logic [SW-1:0] slot_w, slot_s;
  logic c_out_w, c_out_s, slot0_w, slot0_s;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [SW-1:0] slot;
    logic          c_out;
    logic          slot0;
  } exp_t;

  exp_t sb_q[$];
  logic [DW-1:0] m_store [2][CH];
  int m_slot;

  ym_tdm_cnt dut (
    .MCLK(MCLK), .MRESET_n(MRESET_n), .c1(c1), .c2(c2), .sync(sync), .c_in(c_in),
    .dec(dec), .clr(clr), .set(set), .load(load), .load_val(load_val),
    .val(val_w), .slot(slot_w), .c_out(c_out_w), .slot0(slot0_w)
  );

  ym_tdm_cnt #(.SATURATE(1)) dut_sat (
    .MCLK(MCLK), .MRESET_n(MRESET_n), .c1(c1), .c2(c2), .sync(sync), .c_in(c_in),
    .dec(dec), .clr(clr), .set(set), .load(load), .load_val(load_val),
    .val(val_s), .slot(slot_s), .c_out(c_out_s), .slot0(slot0_s)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  function automatic void model_next(input logic [DW-1:0] v, input bit sat,
                                     output logic [DW-1:0] nv, output logic co);
    co = 1'b0;
    if (clr)        nv = '0;
    else if (load)  nv = load_val;
    else if (set)   nv = {DW{1'b1}};
    else if (!c_in) nv = v;
    else if (!dec) begin
      if (v == {DW{1'b1}}) begin co = 1'b1; nv = sat ? v : '0; end
      else nv = v + 1'b1;
    end else begin
      if (v == '0) begin co = 1'b1; nv = sat ? v : {DW{1'b1}}; end
      else nv = v - 1'b1;
    end
  endfunction

  task automatic drive(input logic ci, input logic d, input logic cl, input logic ld,
                       input logic st, input logic sy, input logic [DW-1:0] lv);
    c_in = ci; dec = d; clr = cl; load = ld; set = st; sync = sy; load_val = lv;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) for (int i = 0; i < CH; i++) m_store[k][i] = '0;
    m_slot = 0;
    sb_q.delete();
  endtask

  // One c1 cycle, optional idle cycles with junk controls, one c2 cycle; entered at posedge+1.
  task automatic tick(input int idle = 0);
    logic [DW-1:0] nv [2];
    logic co [2];
    logic sync_c1;
    exp_t e, got;
    sync_c1 = sync;
    for (int k = 0; k < 2; k++) begin
      model_next(m_store[k][0], k == 1, nv[k], co[k]);
      e = '{val: m_store[k][0], slot: SW'(m_slot), c_out: co[k], slot0: (m_slot == 0)};
      sb_q.push_back(e);
    end
    c1 = 1'b1;
    #1;
    e = sb_q.pop_front();
    got = '{val: val_w, slot: slot_w, c_out: c_out_w, slot0: slot0_w};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL wrap_out t=%0t got val=%0d slot=%0d c_out=%b slot0=%b need val=%0d slot=%0d c_out=%b slot0=%b",
               $time, got.val, got.slot, got.c_out, got.slot0, e.val, e.slot, e.c_out, e.slot0);
    end
    e = sb_q.pop_front();
    got = '{val: val_s, slot: slot_s, c_out: c_out_s, slot0: slot0_s};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sat_out t=%0t got val=%0d slot=%0d c_out=%b slot0=%b need val=%0d slot=%0d c_out=%b slot0=%b",
               $time, got.val, got.slot, got.c_out, got.slot0, e.val, e.slot, e.c_out, e.slot0);
    end
    @(posedge MCLK); #1;
    c1 = 1'b0;
    for (int i = 0; i < idle; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), DW'($urandom));
      @(posedge MCLK); #1;
    end
    c2 = 1'b1;
    @(posedge MCLK); #1;
    c2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < CH - 1; i++) m_store[k][i] = m_store[k][i+1];
      m_store[k][CH-1] = nv[k];
    end
    m_slot = sync_c1 ? 0 : (m_slot + 1) % CH;
    drive(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic apply_reset();
    c1 = 1'b0; c2 = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0);
    MRESET_n = 1'b0;
    repeat (2) @(posedge MCLK);
    #1 MRESET_n = 1'b1;
    model_reset();
    @(posedge MCLK); #1;
  endtask

  task automatic test_reset();
    c1 = 1'b0; c2 = 1'b0;
    drive(1, 1, 0, 0, 0, 0, '0);
    MRESET_n = 1'b0;
    #1;
    checks += 5;
    if (val_w !== '0)    begin errors++; $display("FAIL reset_val got %0d need 0", val_w); end
    if (slot_w !== '0)   begin errors++; $display("FAIL reset_slot got %0d need 0", slot_w); end
    if (slot0_w !== 1'b1) begin errors++; $display("FAIL reset_slot0 got %b need 1", slot0_w); end
    if (c_out_w !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b need 0", c_out_w); end
    if (c_out_s !== 1'b0) begin errors++; $display("FAIL reset_c_out_sat got %b need 0", c_out_s); end
    apply_reset();
  endtask

  task automatic test_count_all();
    apply_reset();
    for (int i = 0; i < CH; i++) begin
      drive(1, 0, 0, 0, 0, 0, '0);
      checks++;
      if (slot_w !== SW'(i)) begin errors++; $display("FAIL seq_slot got %0d need %0d", slot_w, i); end
      tick(i % 2);
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (val_w !== 4'd1 || slot_w !== SW'(i)) begin
        errors++; $display("FAIL revisit got val=%0d slot=%0d need val=1 slot=%0d", val_w, slot_w, i);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int visits = 0;
    apply_reset();
    for (int t = 0; t < 17 * CH; t++) begin
      drive(m_slot == 2 && visits < 16, 0, 0, 0, 0, 0, '0);
      if (m_slot == 2 && visits == 15) begin
        #1;
        checks += 3;
        if (val_w !== 4'd15) begin errors++; $display("FAIL wrap_pre got %0d need 15", val_w); end
        if (c_out_w !== 1'b1) begin errors++; $display("FAIL wrap_carry got %b need 1", c_out_w); end
        if (c_out_s !== 1'b1) begin errors++; $display("FAIL sat_hi_hit got %b need 1", c_out_s); end
      end
      if (m_slot == 2 && visits == 16) begin
        checks += 2;
        if (val_w !== 4'd0)  begin errors++; $display("FAIL wrap_post got %0d need 0", val_w); end
        if (val_s !== 4'd15) begin errors++; $display("FAIL sat_hi_hold got %0d need 15", val_s); end
      end
      if (m_slot == 2) visits++;
      tick();
    end
  endtask

  task automatic test_sat_dec();
    apply_reset();
    drive(1, 1, 0, 0, 0, 0, '0);
    #1;
    checks += 2;
    if (c_out_s !== 1'b1) begin errors++; $display("FAIL sat_lo_hit got %b need 1", c_out_s); end
    if (c_out_w !== 1'b1) begin errors++; $display("FAIL borrow got %b need 1", c_out_w); end
    tick();
    repeat (CH - 1) tick();
    checks += 2;
    if (val_s !== 4'd0)  begin errors++; $display("FAIL sat_lo_hold got %0d need 0", val_s); end
    if (val_w !== 4'd15) begin errors++; $display("FAIL dec_wrap got %0d need 15", val_w); end
    tick();
  endtask

  task automatic test_priority();
    apply_reset();
    repeat (3) tick();
    drive(0, 0, 0, 1, 0, 0, 4'd7);
    tick();
    repeat (CH - 1) tick();
    drive(1, 1, 1, 1, 1, 0, 4'd5);
    #1;
    checks++;
    if (c_out_w !== 1'b0) begin errors++; $display("FAIL clr_c_out got %b need 0", c_out_w); end
    tick();
    repeat (CH - 1) tick();
    checks++;
    if (val_w !== 4'd0 || slot_w !== 3'd3) begin
      errors++; $display("FAIL clr_priority got val=%0d slot=%0d need val=0 slot=3", val_w, slot_w);
    end
    tick();
  endtask

  task automatic test_sync();
    apply_reset();
    repeat (3) tick();
    drive(0, 0, 0, 1, 0, 0, 4'd9);
    tick();
    drive(0, 0, 0, 0, 0, 1, '0);
    tick(1);
    checks++;
    if (slot_w !== 3'd0 || slot0_w !== 1'b1) begin
      errors++; $display("FAIL sync_slot got slot=%0d slot0=%b need 0 1", slot_w, slot0_w);
    end
    repeat (4) tick();
    checks++;
    if (val_w !== 4'd9) begin errors++; $display("FAIL sync_keep got %0d need 9", val_w); end
    tick();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < CH + 2; i++) begin drive(1, 0, 0, 0, 0, 0, '0); tick(); end
    drive(1, 1, 0, 0, 0, 0, '0);
    c1 = 1'b1;
    @(posedge MCLK); #1;
    c1 = 1'b0;
    MRESET_n = 1'b0;
    #1;
    checks++;
    if (val_w !== '0 || slot_w !== '0 || slot0_w !== 1'b1 || c_out_w !== 1'b0 || c_out_s !== 1'b0)
    begin
      errors++;
      $display("FAIL mid_reset got val=%0d slot=%0d slot0=%b c_out=%b/%b need 0 0 1 0/0",
               val_w, slot_w, slot0_w, c_out_w, c_out_s);
    end
    @(posedge MCLK); #1;
    MRESET_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 2 * CH; i++) begin drive(i < CH, 0, 0, 0, 0, 0, '0); tick(); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
            DW'($urandom));
      tick($urandom_range(0, 2));
    end
  endtask

  initial begin
    MRESET_n = 1'b0;
    c1 = 1'b0; c2 = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0);
    model_reset();
    @(posedge MCLK); #1;
    test_reset();
    test_count_all();
    test_wrap();
    test_sat_dec();
    test_priority();
    test_sync();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
